// File: rtl/input_conditioner.sv
// Synchronizes and debounces two slide switches and two push buttons; buttons step a 3-bit mux select.
// Latency: raw level to sw0/sw1 in DEBOUNCE_N+2 edges; select updates one edge after a debounced press.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_N = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_sw0,
    input  logic       raw_sw1,
    input  logic       raw_up,
    input  logic       raw_dn,
    output logic       sw0,
    output logic       sw1,
    output logic [2:0] select,
    output logic       sel_changed
);

    localparam logic [15:0] LP_LAST = 16'(DEBOUNCE_N - 1);

    // Bit order in every 4-bit vector: {dn, up, sw1, sw0}
    logic [3:0]  r_s1;
    logic [3:0]  r_s2;
    logic [3:0]  r_stable;
    logic [15:0] r_cnt [4];
    logic [1:0]  r_prev;
    logic [2:0]  r_select;
    logic        r_sel_changed;

    logic w_press_up;
    logic w_press_dn;

    assign w_press_up = r_stable[2] & ~r_prev[0];
    assign w_press_dn = r_stable[3] & ~r_prev[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1          <= '0;
            r_s2          <= '0;
            r_stable      <= '0;
            r_prev        <= '0;
            r_select      <= '0;
            r_sel_changed <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= {raw_dn, raw_up, raw_sw1, raw_sw0};
            r_s2   <= r_s1;
            r_prev <= r_stable[3:2];

            // Any matching cycle restarts the count, which rejects short glitches.
            for (int i = 0; i < 4; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_LAST) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end

            // Simultaneous up and down presses cancel and leave no pulse.
            if (w_press_up && !w_press_dn) begin
                r_select      <= r_select + 3'd1;
                r_sel_changed <= 1'b1;
            end else if (w_press_dn && !w_press_up) begin
                r_select      <= r_select - 3'd1;
                r_sel_changed <= 1'b1;
            end else begin
                r_sel_changed <= 1'b0;
            end
        end
    end

    assign sw0         = r_stable[0];
    assign sw1         = r_stable[1];
    assign select      = r_select;
    assign sel_changed = r_sel_changed;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner at DEBOUNCE_N=4: directed scenarios plus randomized toggling
// against a sample-history reference model.
module tb_input_conditioner;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw = 4'b0000;   // {dn, up, sw1, sw0}
    logic       sw0;
    logic       sw1;
    logic [2:0] select;
    logic       sel_changed;

    int total = 0;
    int bad   = 0;
    int n_pulse = 0;

    input_conditioner #(.DEBOUNCE_N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_sw0    (raw[0]),
        .raw_sw1    (raw[1]),
        .raw_up     (raw[2]),
        .raw_dn     (raw[3]),
        .sw0        (sw0),
        .sw1        (sw1),
        .select     (select),
        .sel_changed(sel_changed)
    );

    always #5 clk = ~clk;

    // Reference model: list of raw samples taken at each edge, the run length of
    // edges on which the twice-delayed sample disagreed with the accepted level,
    // and the accepted levels one edge ago to detect rising buttons.
    logic [3:0] q_raw[$];
    int         m_run [4];
    logic [3:0] m_stab;
    logic [1:0] m_btn_old;
    int         m_sel;
    logic       m_chg;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_raw.delete();
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_stab    = '0;
        m_btn_old = '0;
        m_sel     = 0;
        m_chg     = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic [3:0] seen;
        logic       up_ev;
        logic       dn_ev;
        seen = (q_raw.size() >= 2) ? q_raw[q_raw.size()-2] : 4'b0000;
        q_raw.push_back(r);
        if (q_raw.size() > 2) void'(q_raw.pop_front());
        up_ev = m_stab[2] && !m_btn_old[0];
        dn_ev = m_stab[3] && !m_btn_old[1];
        m_btn_old = m_stab[3:2];
        for (int i = 0; i < 4; i++) begin
            if (seen[i] != m_stab[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == N) begin
                    m_stab[i] = seen[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (up_ev != dn_ev) begin
            m_sel = up_ev ? (m_sel + 1) % 8 : (m_sel + 7) % 8;
            m_chg = 1'b1;
        end else begin
            m_chg = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("sw0", sw0, m_stab[0]);
        chk("sw1", sw1, m_stab[1]);
        chk("select", select, m_sel);
        chk("sel_changed", sel_changed, m_chg);
    endtask

    // Called at a negedge: apply raw, advance one rising edge, check at next negedge.
    task automatic tick(input logic [3:0] r);
        raw = r;
        @(posedge clk);
        if (!rst) model_edge(r);
        @(negedge clk);
        if (sel_changed) n_pulse++;
        check_outputs();
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_sw0", sw0, 0);
        chk("rst_sw1", sw1, 0);
        chk("rst_select", select, 0);
        chk("rst_chg", sel_changed, 0);
        @(negedge clk);
        for (int i = 0; i < cycles; i++) tick(4'($urandom_range(0, 15)));
        rst = 1'b0;
    endtask

    task automatic press(input logic [3:0] btn);
        for (int i = 0; i < 8; i++) tick(btn);
        for (int i = 0; i < 8; i++) tick(4'b0000);
    endtask

    initial begin
        int         hold [4];
        logic [3:0] rv;
        int         edges;

        model_reset();
        @(negedge clk);
        apply_reset(3);

        // Switch rises on edge N+2 = 6, not 5.
        tick(4'b0000);
        for (int i = 1; i <= 5; i++) tick(4'b0001);
        chk("sw0_edge5", sw0, 0);
        tick(4'b0001);
        chk("sw0_edge6", sw0, 1);
        for (int i = 0; i < 4; i++) tick(4'b0001);

        // Glitchy sw1: 3 high, 1 low, 3 high never reaches N consecutive.
        for (int i = 0; i < 3; i++) tick(4'b0011);
        tick(4'b0001);
        for (int i = 0; i < 3; i++) tick(4'b0011);
        for (int i = 0; i < 10; i++) tick(4'b0001);
        chk("sw1_glitch", sw1, 0);

        // Eight up presses from reset walk select through all codes and wrap.
        apply_reset(2);
        n_pulse = 0;
        for (int p = 1; p <= 8; p++) begin
            press(4'b0100);
            chk("up_sel", select, p % 8);
        end
        chk("up_pulses", n_pulse, 8);

        // Down from 000 wraps to 111.
        n_pulse = 0;
        press(4'b1000);
        chk("dn_wrap", select, 7);
        chk("dn_pulses", n_pulse, 1);

        // Both buttons together: no step on press or release.
        n_pulse = 0;
        for (int i = 0; i < 12; i++) tick(4'b1100);
        for (int i = 0; i < 12; i++) tick(4'b0000);
        chk("both_sel", select, 7);
        chk("both_pulses", n_pulse, 0);

        // Button held through reset release steps exactly once after debounce.
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        tick(4'b0100);
        rst = 1'b0;
        n_pulse = 0;
        for (int i = 0; i < 12; i++) tick(4'b0100);
        for (int i = 0; i < 8; i++) tick(4'b0000);
        chk("held_rst_sel", select, 1);
        chk("held_rst_pulses", n_pulse, 1);

        // Reset mid-count discards partial progress on sw0.
        apply_reset(2);
        for (int i = 0; i < 4; i++) tick(4'b0001);
        chk("pre_rst_sw0", sw0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        chk("midcnt_rst_sw0", sw0, 0);
        @(negedge clk);
        tick(4'b0001);
        tick(4'b0001);
        rst = 1'b0;
        edges = 0;
        while (!sw0 && edges < 20) begin
            tick(4'b0001);
            edges++;
        end
        chk("post_rst_edges", edges, N + 2);

        // Randomized per-input level holds, including occasional resets.
        apply_reset(2);
        rv = '0;
        for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 7);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    rv[i]   = ~rv[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                          : $urandom_range(5, 14);
                end
            end
            tick(rv);
            if ($urandom_range(0, 999) == 0) apply_reset($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_N, default 16, consecutive stable clocks required to accept a new input level; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 raw_sw0  input  1  unsynchronized slide switch 0.
REQ-005 raw_sw1  input  1  unsynchronized slide switch 1.
REQ-006 raw_up  input  1  unsynchronized push button; steps select up.
REQ-007 raw_dn  input  1  unsynchronized push button; steps select down.
REQ-008 sw0  output  1  debounced switch 0; feeds the gate-select mux operand sw0.
REQ-009 sw1  output  1  debounced switch 1; feeds the gate-select mux operand sw1.
REQ-010 select  output  3  registered operation code for the mux, 000..111.
REQ-011 sel_changed  output  1  one-cycle pulse coincident with any select update.

Function
REQ-012 Each raw input SHALL pass through its own 2-flop synchronizer (s1, s2) before any other use.
REQ-013 Each input SHALL have an independent debouncer: stable bit plus 16-bit counter cnt.
REQ-014 Debouncer, per clock: s2 == stable -> cnt <= 0; s2 != stable and cnt < DEBOUNCE_N-1 -> cnt <= cnt+1; s2 != stable and cnt == DEBOUNCE_N-1 -> stable <= s2, cnt <= 0.
REQ-015 A mismatch interrupted by even one matching cycle SHALL restart the count from 0 (glitch rejection).
REQ-016 Latency: a raw level first sampled on edge 1 and held SHALL appear on the stable bit at edge DEBOUNCE_N+2, never earlier.
REQ-017 sw0/sw1 SHALL be the stable bits of their debouncers, driven directly from flops.
REQ-018 Each button SHALL have a prev flop; press event = stable & ~prev, evaluated combinationally, prev <= stable every clock.
REQ-019 select update on the edge after a press event: up only -> select+1 mod 8; down only -> select-1 mod 8; both in same cycle -> no change.
REQ-020 Wrap-around: 111 + up -> 000; 000 + down -> 111.
REQ-021 sel_changed SHALL be 1 for exactly the cycle following an edge on which select was written, 0 otherwise; simultaneous up+down SHALL NOT pulse it.
REQ-022 A held button SHALL produce exactly one step; release SHALL produce none.
REQ-023 Switch inputs SHALL have no effect on select and buttons no effect on sw0/sw1.
REQ-024 Block SHALL be purely synchronous to clk apart from rst; no latches, no derived clocks.

Reset
REQ-025 rst high SHALL immediately clear all synchronizer, stable, prev, cnt flops and select; sw0=0, sw1=0, select=000, sel_changed=0.
REQ-026 Reset asserted mid-count SHALL discard the partial count; after release debouncing restarts from cnt=0.
REQ-027 A button held through reset release SHALL NOT generate a press at stable=prev=0 until its debounced rise completes, then step once.
REQ-028 Outputs SHALL hold reset values while rst is high regardless of raw inputs.

Verification
REQ-029 DEBOUNCE_N=4: raw_sw0 0->1 held -> sw0 rises at edge 6 after first sampling edge, not edge 5.
REQ-030 DEBOUNCE_N=4: raw_sw1 pulses high 3 cycles, low 1, high 3 -> sw1 stays 0 throughout.
REQ-031 From reset, 8 clean raw_up presses -> select 001,010,...,111,000; sel_changed pulses exactly 8 times.
REQ-032 select=000, one raw_dn press -> select=111, one sel_changed pulse.
REQ-033 raw_up and raw_dn asserted on the same cycle and held -> select unchanged, sel_changed never 1; both released -> no change.
REQ-034 rst asserted with cnt=2 on raw_sw0 mismatch, then released with raw_sw0 still 1 -> sw0 rises DEBOUNCE_N+2 edges after release.
